// File: rtl/sobel_filter_pkg.sv
// Shared constants, kernel weights and FSM state type for the 3x3 Sobel filter.
package sobel_filter_pkg;

    localparam int CH_W  = 8;
    localparam int PIX_W = 3 * CH_W;
    localparam int WIN_N = 9;
    localparam int ACC_W = 12;
    localparam int CNT_W = 4;

    // Row-major 3x3 kernels, index k = row*3 + column
    localparam logic signed [2:0] GX_W [WIN_N] = '{
        -3'sd1, 3'sd0, 3'sd1,
        -3'sd2, 3'sd0, 3'sd2,
        -3'sd1, 3'sd0, 3'sd1
    };
    localparam logic signed [2:0] GY_W [WIN_N] = '{
        -3'sd1, -3'sd2, -3'sd1,
         3'sd0,  3'sd0,  3'sd0,
         3'sd1,  3'sd2,  3'sd1
    };

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

endpackage

// File: rtl/sobel_filter_channel.sv
// One colour channel: gx/gy accumulation over a window and saturating |gx|+|gy|.
module sobel_channel
    import sobel_filter_pkg::*;
#(
    parameter int PCH_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             acc_en,
    input  logic             acc_clr,
    input  logic [CNT_W-1:0] idx,
    input  logic [PCH_W-1:0] pix,
    output logic [PCH_W-1:0] mag
);

    logic signed [ACC_W-1:0] gx_reg, gy_reg;
    logic signed [ACC_W-1:0] pix_s, wx_ext, wy_ext, gx_term, gy_term;
    logic signed [2:0]       wx, wy;
    logic        [ACC_W-1:0] abs_x, abs_y, sum;

    assign wx      = GX_W[idx];
    assign wy      = GY_W[idx];
    assign wx_ext  = ACC_W'(wx);
    assign wy_ext  = ACC_W'(wy);
    assign pix_s   = {{(ACC_W-PCH_W){1'b0}}, pix};
    assign gx_term = wx_ext * pix_s;
    assign gy_term = wy_ext * pix_s;

    // The first pixel of a window replaces the old sum instead of adding to it
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            gx_reg <= '0;
            gy_reg <= '0;
        end else if (acc_en) begin
            gx_reg <= acc_clr ? gx_term : gx_reg + gx_term;
            gy_reg <= acc_clr ? gy_term : gy_reg + gy_term;
        end
    end

    always_comb begin
        abs_x = gx_reg[ACC_W-1] ? ACC_W'(-gx_reg) : ACC_W'(gx_reg);
        abs_y = gy_reg[ACC_W-1] ? ACC_W'(-gy_reg) : ACC_W'(gy_reg);
        sum   = abs_x + abs_y;
        mag   = (sum > ACC_W'({PCH_W{1'b1}})) ? {PCH_W{1'b1}} : sum[PCH_W-1:0];
    end

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge magnitude on R, G and B with independent result handshakes.
module sobel_filter #(
    parameter int CH_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              i_rgb_busy,
    input  logic              i_rgb_vld,
    input  logic [3*CH_W-1:0] i_rgb_data,
    input  logic              o_newR_busy,
    output logic              o_newR_vld,
    output logic [CH_W-1:0]   o_newR_data,
    input  logic              o_newG_busy,
    output logic              o_newG_vld,
    output logic [CH_W-1:0]   o_newG_data,
    input  logic              o_newB_busy,
    output logic              o_newB_vld,
    output logic [CH_W-1:0]   o_newB_data
);
    import sobel_filter_pkg::*;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2:0]         vld_reg, vld_next;
    logic [3*CH_W-1:0]  data_reg;
    logic [3*CH_W-1:0]  mag;
    logic [2:0]         sink_busy;
    logic               accept;
    logic               load;

    assign sink_busy = {o_newB_busy, o_newG_busy, o_newR_busy};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gen_ch
            sobel_channel #(.PCH_W(CH_W)) u_ch (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .acc_en  (accept),
                .acc_clr (cnt_reg == '0),
                .idx     (cnt_reg),
                .pix     (i_rgb_data[gi*CH_W +: CH_W]),
                .mag     (mag[gi*CH_W +: CH_W])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        vld_next   = vld_reg;
        accept     = 1'b0;
        load       = 1'b0;
        case (state_reg)
            COLLECT: begin
                if (i_rgb_vld) begin
                    accept = 1'b1;
                    if (cnt_reg == CNT_W'(WIN_N - 1)) begin
                        cnt_next   = '0;
                        state_next = COMPUTE;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            COMPUTE: begin
                load       = 1'b1;
                vld_next   = 3'b111;
                state_next = OUTPUT;
            end
            OUTPUT: begin
                // Each channel retires on its own transfer; leave once all are gone
                vld_next = vld_reg & sink_busy;
                if (vld_next == 3'b000) begin
                    state_next = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
                cnt_next   = '0;
                vld_next   = 3'b000;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg <= COLLECT;
            cnt_reg   <= '0;
            vld_reg   <= 3'b000;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            vld_reg   <= vld_next;
            if (load) begin
                data_reg <= mag;
            end
        end
    end

    assign i_rgb_busy  = (state_reg != COLLECT);
    assign o_newR_vld  = vld_reg[0];
    assign o_newG_vld  = vld_reg[1];
    assign o_newB_vld  = vld_reg[2];
    assign o_newR_data = data_reg[0*CH_W +: CH_W];
    assign o_newG_data = data_reg[1*CH_W +: CH_W];
    assign o_newB_data = data_reg[2*CH_W +: CH_W];

endmodule

// File: tb/tb_sobel_filter.sv
// Directed-vector bench for sobel_filter: table of windows plus handshake corner sequences.
module tb_sobel_filter;

    typedef logic [23:0] win_t [9];

    typedef struct {
        string      name;
        win_t       pix;
        logic [7:0] er;
        logic [7:0] eg;
        logic [7:0] eb;
    } vec_t;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_rgb_busy;
    logic        i_rgb_vld;
    logic [23:0] i_rgb_data;
    logic        o_newR_busy, o_newG_busy, o_newB_busy;
    logic        o_newR_vld,  o_newG_vld,  o_newB_vld;
    logic [7:0]  o_newR_data, o_newG_data, o_newB_data;

    int          checks_total = 0;
    int          checks_passed = 0;
    int          cyc = 0;
    bit          b2b_on = 1'b0;
    logic [7:0]  qr[$], qg[$], qb[$];
    int          acc_t[$];

    int KX [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int KY [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

    sobel_filter #(.CH_W(8)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_rgb_busy  (i_rgb_busy),
        .i_rgb_vld   (i_rgb_vld),
        .i_rgb_data  (i_rgb_data),
        .o_newR_busy (o_newR_busy),
        .o_newR_vld  (o_newR_vld),
        .o_newR_data (o_newR_data),
        .o_newG_busy (o_newG_busy),
        .o_newG_vld  (o_newG_vld),
        .o_newG_data (o_newG_data),
        .o_newB_busy (o_newB_busy),
        .o_newB_vld  (o_newB_vld),
        .o_newB_data (o_newB_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record output transfers and input acceptances just after the falling edge
    always @(negedge clk) begin
        #1;
        if (o_newR_vld && !o_newR_busy) qr.push_back(o_newR_data);
        if (o_newG_vld && !o_newG_busy) qg.push_back(o_newG_data);
        if (o_newB_vld && !o_newB_busy) qb.push_back(o_newB_data);
        if (b2b_on && i_rgb_vld && !i_rgb_busy) acc_t.push_back(cyc);
    end

    task automatic check(input string nm, input int act, input int req);
        checks_total++;
        if (act == req) begin
            checks_passed++;
        end else begin
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic logic [7:0] sobel_ref(input win_t w, input int ch);
        int gx = 0;
        int gy = 0;
        int v, s;
        for (int k = 0; k < 9; k++) begin
            v  = int'((w[k] >> (8 * ch)) & 24'hFF);
            gx += KX[k] * v;
            gy += KY[k] * v;
        end
        s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (s > 255) ? 8'd255 : 8'(s);
    endfunction

    // Called and returns at a falling edge; the accepting rising edge lies in between
    task automatic send_pixel(input logic [23:0] p);
        int t = 0;
        i_rgb_vld  = 1'b1;
        i_rgb_data = p;
        while (i_rgb_busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("input_accept_timeout", 1, 0);
        @(negedge clk);
        i_rgb_vld = 1'b0;
    endtask

    task automatic send_window(input win_t w);
        for (int k = 0; k < 9; k++) send_pixel(w[k]);
    endtask

    task automatic run_window(input string nm, input win_t w,
                              input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        send_window(w);
        check({nm, "_compute_busy"}, int'(i_rgb_busy), 1);
        check({nm, "_compute_vld"}, int'({o_newB_vld, o_newG_vld, o_newR_vld}), 0);
        @(negedge clk);
        check({nm, "_vld"}, int'({o_newB_vld, o_newG_vld, o_newR_vld}), 7);
        check({nm, "_R"}, int'(o_newR_data), int'(er));
        check({nm, "_G"}, int'(o_newG_data), int'(eg));
        check({nm, "_B"}, int'(o_newB_data), int'(eb));
        $display("window %s: R=%0d G=%0d B=%0d (expect %0d %0d %0d)",
                 nm, o_newR_data, o_newG_data, o_newB_data, er, eg, eb);
        @(negedge clk);
        check({nm, "_vld_clear"}, int'({o_newB_vld, o_newG_vld, o_newR_vld}), 0);
        check({nm, "_busy_drop"}, int'(i_rgb_busy), 0);
    endtask

    vec_t vecs [10];
    win_t rw [3];
    win_t wtmp;

    initial begin
        vecs[0].name = "uniform";
        vecs[0].pix  = '{default: 24'h646464};
        vecs[0].er = 8'd0;   vecs[0].eg = 8'd0;   vecs[0].eb = 8'd0;
        vecs[1].name = "vedge_R";
        vecs[1].pix  = '{24'h0, 24'h0, 24'h0000FF, 24'h0, 24'h0, 24'h0000FF, 24'h0, 24'h0, 24'h0000FF};
        vecs[1].er = 8'd255; vecs[1].eg = 8'd0;   vecs[1].eb = 8'd0;
        vecs[2].name = "col2_R10";
        vecs[2].pix  = '{24'h0, 24'h0, 24'h00000A, 24'h0, 24'h0, 24'h00000A, 24'h0, 24'h0, 24'h00000A};
        vecs[2].er = 8'd40;  vecs[2].eg = 8'd0;   vecs[2].eb = 8'd0;
        vecs[3].name = "row2_B20";
        vecs[3].pix  = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h140000, 24'h140000, 24'h140000};
        vecs[3].er = 8'd0;   vecs[3].eg = 8'd0;   vecs[3].eb = 8'd80;
        vecs[4].name = "k8_G10";
        vecs[4].pix  = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h000A00};
        vecs[4].er = 8'd0;   vecs[4].eg = 8'd20;  vecs[4].eb = 8'd0;
        vecs[5].name = "hedge_G";
        vecs[5].pix  = '{24'h00FF00, 24'h00FF00, 24'h00FF00, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
        vecs[5].er = 8'd0;   vecs[5].eg = 8'd255; vecs[5].eb = 8'd0;
        vecs[6].name = "col0_B5";
        vecs[6].pix  = '{24'h050000, 24'h0, 24'h0, 24'h050000, 24'h0, 24'h0, 24'h050000, 24'h0, 24'h0};
        vecs[6].er = 8'd0;   vecs[6].eg = 8'd0;   vecs[6].eb = 8'd20;
        vecs[7].name = "k0_rgb";
        vecs[7].pix  = '{24'h030201, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
        vecs[7].er = 8'd2;   vecs[7].eg = 8'd4;   vecs[7].eb = 8'd6;
        vecs[8].name = "k0_R100";
        vecs[8].pix  = '{24'h000064, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
        vecs[8].er = 8'd200; vecs[8].eg = 8'd0;   vecs[8].eb = 8'd0;
        vecs[9].name = "center_only";
        vecs[9].pix  = '{24'h0, 24'h0, 24'h0, 24'h0, 24'hFFFFFF, 24'h0, 24'h0, 24'h0, 24'h0};
        vecs[9].er = 8'd0;   vecs[9].eg = 8'd0;   vecs[9].eb = 8'd0;

        i_rst = 1'b0;
        i_rgb_vld = 1'b0;
        i_rgb_data = 24'h0;
        o_newR_busy = 1'b0;
        o_newG_busy = 1'b0;
        o_newB_busy = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_busy", int'(i_rgb_busy), 0);
        check("reset_vld", int'({o_newB_vld, o_newG_vld, o_newR_vld}), 0);
        check("reset_data", int'({o_newB_data, o_newG_data, o_newR_data}), 0);
        i_rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_window(vecs[i].name, vecs[i].pix, vecs[i].er, vecs[i].eg, vecs[i].eb);
        end

        // G sink stalls for five cycles while R and B drain at once
        o_newG_busy = 1'b1;
        wtmp = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0A0A0A};
        send_window(wtmp);
        @(negedge clk);
        check("bp_vld_all", int'({o_newB_vld, o_newG_vld, o_newR_vld}), 7);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_vld_c%0d", c), int'({o_newB_vld, o_newG_vld, o_newR_vld}), 2);
            check($sformatf("bp_G_c%0d", c), int'(o_newG_data), 20);
            check($sformatf("bp_busy_c%0d", c), int'(i_rgb_busy), 1);
        end
        check("bp_R_data_hold", int'(o_newR_data), 20);
        check("bp_B_data_hold", int'(o_newB_data), 20);
        o_newG_busy = 1'b0;
        @(negedge clk);
        check("bp_G_released_vld", int'({o_newB_vld, o_newG_vld, o_newR_vld}), 0);
        check("bp_G_released_busy", int'(i_rgb_busy), 0);
        $display("backpressure: G held 5 cycles, data=%0d", o_newG_data);

        // Partial window then asynchronous reset
        for (int k = 0; k < 4; k++) send_pixel(24'hFFFFFF);
        i_rst = 1'b0;
        #1;
        check("midrst_busy", int'(i_rgb_busy), 0);
        check("midrst_vld", int'({o_newB_vld, o_newG_vld, o_newR_vld}), 0);
        check("midrst_data", int'({o_newB_data, o_newG_data, o_newR_data}), 0);
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        wtmp = '{default: 24'h101010};
        run_window("after_reset", wtmp, 8'd0, 8'd0, 8'd0);

        // Back-to-back windows with the input held valid
        qr.delete(); qg.delete(); qb.delete();
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 9; k++) begin
                if (w == 0)
                    rw[w][k] = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
                else
                    rw[w][k] = 24'($urandom);
            end
        end
        b2b_on = 1'b1;
        for (int w = 0; w < 3; w++) send_window(rw[w]);
        repeat (4) @(negedge clk);
        b2b_on = 1'b0;
        check("b2b_count_R", qr.size(), 3);
        check("b2b_count_G", qg.size(), 3);
        check("b2b_count_B", qb.size(), 3);
        if (qr.size() == 3 && qg.size() == 3 && qb.size() == 3) begin
            for (int w = 0; w < 3; w++) begin
                check($sformatf("b2b_w%0d_R", w), int'(qr[w]), int'(sobel_ref(rw[w], 0)));
                check($sformatf("b2b_w%0d_G", w), int'(qg[w]), int'(sobel_ref(rw[w], 1)));
                check($sformatf("b2b_w%0d_B", w), int'(qb[w]), int'(sobel_ref(rw[w], 2)));
                $display("b2b window %0d: R=%0d G=%0d B=%0d", w, qr[w], qg[w], qb[w]);
            end
        end
        check("b2b_accepts", acc_t.size(), 27);
        if (acc_t.size() == 27) begin
            check("b2b_in_window_span", acc_t[8] - acc_t[0], 8);
            check("b2b_period_0_1", acc_t[9] - acc_t[0], 11);
            check("b2b_period_1_2", acc_t[18] - acc_t[9], 11);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
